// File: rtl/bcd_digit_collector_if.sv
// Digit-stream and converter-launch signals of bcd_digit_collector.
// slave is the collector's view; master is the upstream/converter side.
interface bcd_digit_collector_if #(
    parameter int DIGITS = 4,
    parameter int CW     = $clog2(DIGITS + 1)
);
    logic                  digit_valid_i;
    logic [3:0]            digit_i;
    logic                  digit_last_i;
    logic                  digit_ready_o;
    logic                  clear_i;
    logic [4*DIGITS-1:0]   bcd_o;
    logic [CW-1:0]         count_o;
    logic                  start_o;
    logic                  conv_ready_i;
    logic                  conv_done_i;
    logic                  busy_o;
    logic                  error_o;

    modport slave (
        input  digit_valid_i, digit_i, digit_last_i, clear_i, conv_ready_i, conv_done_i,
        output digit_ready_o, bcd_o, count_o, start_o, busy_o, error_o
    );

    modport master (
        output digit_valid_i, digit_i, digit_last_i, clear_i, conv_ready_i, conv_done_i,
        input  digit_ready_o, bcd_o, count_o, start_o, busy_o, error_o
    );
endinterface

// File: rtl/bcd_digit_collector.sv
// Collects MSD-first BCD digits into a packed operand and launches the BCD-to-binary converter.
// Optional macro BCD_COLLECTOR_ROLLING_EN: overflow digits roll the window instead of raising error.
module bcd_digit_collector #(
    parameter int DIGITS = 4,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    bcd_digit_collector_if.slave    bus
);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t          state_q, state_n;
    logic [BW-1:0]   bcd_q, bcd_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            err_q, err_n;
    logic            start_q;
    logic            busy_q;
    logic            ready;
    logic            accept;
    logic            digit_ok;
    logic            full;
    logic [BW-1:0]   shifted;

    assign ready = (state_q == S_IDLE) || (state_q == S_COLLECT);

    always_comb begin
        state_n  = state_q;
        bcd_n    = bcd_q;
        cnt_n    = cnt_q;
        err_n    = err_q;
        accept   = bus.digit_valid_i && ready;
        digit_ok = (bus.digit_i <= 4'd9);
        full     = (cnt_q == CW'(DIGITS));
        shifted  = {bcd_q[BW-5:0], bus.digit_i};

        // Clear wins over any simultaneous digit, but cannot abort a running conversion.
        if (bus.clear_i && state_q != S_WAIT) begin
            state_n = S_IDLE;
            bcd_n   = '0;
            cnt_n   = '0;
            err_n   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_COLLECT: begin
                    if (accept) begin
                        if (!digit_ok) begin
                            err_n = 1'b1;
                        end else if (!full) begin
                            bcd_n   = shifted;
                            cnt_n   = cnt_q + CW'(1);
                            state_n = bus.digit_last_i ? S_LAUNCH : S_COLLECT;
                        end else begin
`ifdef BCD_COLLECTOR_ROLLING_EN
                            bcd_n   = shifted;
                            state_n = bus.digit_last_i ? S_LAUNCH : S_COLLECT;
`else
                            // Overflow digit is dropped, but its last flag still launches.
                            err_n = 1'b1;
                            if (bus.digit_last_i) state_n = S_LAUNCH;
`endif
                        end
                    end
                end
                S_LAUNCH: begin
                    if (bus.conv_ready_i) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.conv_done_i) begin
                        state_n = S_IDLE;
                        bcd_n   = '0;
                        cnt_n   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            bcd_q   <= bcd_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
            start_q <= (state_n == S_LAUNCH);
            busy_q  <= (state_n == S_LAUNCH) || (state_n == S_WAIT);
        end
    end

    assign bus.digit_ready_o = ready;
    assign bus.bcd_o         = bcd_q;
    assign bus.count_o       = cnt_q;
    assign bus.start_o       = start_q;
    assign bus.busy_o        = busy_q;
    assign bus.error_o       = err_q;
endmodule

// File: tb/tb_bcd_digit_collector.sv
// Directed bench for bcd_digit_collector (DIGITS=4); honours BCD_COLLECTOR_ROLLING_EN when defined.
module tb_bcd_digit_collector;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bcd_digit_collector_if #(.DIGITS(4)) bus ();

    bcd_digit_collector #(.DIGITS(4)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge, after the accepting rising edge.
    task automatic send_digit(input logic [3:0] d, input logic last);
        bus.digit_valid_i = 1'b1;
        bus.digit_i       = d;
        bus.digit_last_i  = last;
        @(negedge clk);
        bus.digit_valid_i = 1'b0;
        bus.digit_last_i  = 1'b0;
    endtask

    task automatic pulse_done();
        bus.conv_done_i = 1'b1;
        @(negedge clk);
        bus.conv_done_i = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
    endtask

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        rst_n             = 1'b0;
        bus.digit_valid_i = 1'b0;
        bus.digit_i       = 4'd0;
        bus.digit_last_i  = 1'b0;
        bus.clear_i       = 1'b0;
        bus.conv_ready_i  = 1'b1;
        bus.conv_done_i   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_bcd",   32'(bus.bcd_o),   32'h0);
        chk("rst_count", 32'(bus.count_o), 32'h0);
        chk("rst_start", 32'(bus.start_o), 32'h0);
        chk("rst_busy",  32'(bus.busy_o),  32'h0);
        chk("rst_error", 32'(bus.error_o), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.digit_ready_o), 32'h1);

        // 0,0,4,2 with converter ready: one-cycle start, then done returns to idle
        send_digit(4'd0, 1'b0);
        chk("s1_count1", 32'(bus.count_o), 32'h1);
        send_digit(4'd0, 1'b0);
        send_digit(4'd4, 1'b0);
        chk("s1_bcd3", 32'(bus.bcd_o), 32'h0004);
        send_digit(4'd2, 1'b1);
        chk("s1_bcd",   32'(bus.bcd_o),         32'h0042);
        chk("s1_count", 32'(bus.count_o),       32'h4);
        chk("s1_start", 32'(bus.start_o),       32'h1);
        chk("s1_busy",  32'(bus.busy_o),        32'h1);
        chk("s1_ready", 32'(bus.digit_ready_o), 32'h0);
        @(negedge clk);
        chk("s1_start_drop", 32'(bus.start_o), 32'h0);
        chk("s1_wait_busy",  32'(bus.busy_o),  32'h1);
        pulse_clear();
        chk("s1_clr_wait_bcd",  32'(bus.bcd_o),  32'h0042);
        chk("s1_clr_wait_busy", 32'(bus.busy_o), 32'h1);
        pulse_done();
        chk("s1_done_bcd",   32'(bus.bcd_o),         32'h0);
        chk("s1_done_count", 32'(bus.count_o),       32'h0);
        chk("s1_done_ready", 32'(bus.digit_ready_o), 32'h1);
        chk("s1_done_busy",  32'(bus.busy_o),        32'h0);

        // 4,2 with converter stalled for 5 cycles
        bus.conv_ready_i = 1'b0;
        send_digit(4'd4, 1'b0);
        send_digit(4'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("s2_start_hold", 32'(bus.start_o),       32'h1);
            chk("s2_bcd_hold",   32'(bus.bcd_o),         32'h0042);
            chk("s2_ready_low",  32'(bus.digit_ready_o), 32'h0);
            if (i < 4) @(negedge clk);
        end
        bus.conv_ready_i = 1'b1;
        @(negedge clk);
        chk("s2_start_drop", 32'(bus.start_o), 32'h0);
        pulse_done();
        chk("s2_idle", 32'(bus.digit_ready_o), 32'h1);

        // 1,B,7: bad digit dropped, sticky error survives launch until clear
        bus.conv_ready_i = 1'b0;
        send_digit(4'd1, 1'b0);
        send_digit(4'hB, 1'b1);
        chk("s3_bad_count", 32'(bus.count_o), 32'h1);
        chk("s3_bad_start", 32'(bus.start_o), 32'h0);
        chk("s3_bad_err",   32'(bus.error_o), 32'h1);
        send_digit(4'd7, 1'b1);
        chk("s3_bcd",   32'(bus.bcd_o),   32'h0017);
        chk("s3_start", 32'(bus.start_o), 32'h1);
        chk("s3_err",   32'(bus.error_o), 32'h1);
        bus.conv_ready_i = 1'b1;
        @(negedge clk);
        chk("s3_err_wait", 32'(bus.error_o), 32'h1);
        pulse_done();
        chk("s3_err_idle", 32'(bus.error_o), 32'h1);
        pulse_clear();
        chk("s3_err_clr", 32'(bus.error_o), 32'h0);

        // 1,2,3,4,5: overflow behaviour depends on the rolling macro
        bus.conv_ready_i = 1'b0;
        send_digit(4'd1, 1'b0);
        send_digit(4'd2, 1'b0);
        send_digit(4'd3, 1'b0);
        send_digit(4'd4, 1'b0);
        send_digit(4'd5, 1'b1);
`ifdef BCD_COLLECTOR_ROLLING_EN
        chk("s4_bcd", 32'(bus.bcd_o),   32'h2345);
        chk("s4_err", 32'(bus.error_o), 32'h0);
`else
        chk("s4_bcd", 32'(bus.bcd_o),   32'h1234);
        chk("s4_err", 32'(bus.error_o), 32'h1);
`endif
        chk("s4_count", 32'(bus.count_o), 32'h4);
        chk("s4_start", 32'(bus.start_o), 32'h1);
        pulse_clear();
        chk("s4_clr_bcd",   32'(bus.bcd_o),         32'h0);
        chk("s4_clr_start", 32'(bus.start_o),       32'h0);
        chk("s4_clr_err",   32'(bus.error_o),       32'h0);
        chk("s4_clr_ready", 32'(bus.digit_ready_o), 32'h1);

        // 9,8, stray done ignored, then clear; then clear colliding with a digit
        send_digit(4'd9, 1'b0);
        send_digit(4'd8, 1'b0);
        pulse_done();
        chk("s5_bcd",   32'(bus.bcd_o),   32'h0098);
        chk("s5_count", 32'(bus.count_o), 32'h2);
        pulse_clear();
        chk("s5_clr_bcd",   32'(bus.bcd_o),   32'h0);
        chk("s5_clr_count", 32'(bus.count_o), 32'h0);
        send_digit(4'd6, 1'b0);
        bus.clear_i = 1'b1;
        send_digit(4'd3, 1'b1);
        bus.clear_i = 1'b0;
        chk("s5_col_bcd",   32'(bus.bcd_o),   32'h0);
        chk("s5_col_count", 32'(bus.count_o), 32'h0);
        chk("s5_col_start", 32'(bus.start_o), 32'h0);

        // Asynchronous reset while launching
        bus.conv_ready_i = 1'b0;
        send_digit(4'd5, 1'b1);
        chk("s6_start_pre", 32'(bus.start_o), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("s6_rst_start", 32'(bus.start_o), 32'h0);
        chk("s6_rst_busy",  32'(bus.busy_o),  32'h0);
        chk("s6_rst_bcd",   32'(bus.bcd_o),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s6_ready", 32'(bus.digit_ready_o), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bcd_digit_collector.md
# bcd_digit_collector

Assembles a packed BCD operand from a stream of single decimal digits, most-significant digit first, and launches the BCD-to-binary converter with it. It sits directly upstream of the converter. It drives the converter's BCD operand and start strobe, then holds the operand stable until the converter reports done. Invalid digits and overflow are flagged with a sticky error.

## Interface
Parameters:
- DIGITS, default 4: maximum digit count; operand width is 4*DIGITS.
- CW, default $clog2(DIGITS+1): width of count_o.

Ports:
- clk_i, input, 1: single clock; all logic is rising-edge.
- reset_ni, input, 1: reset, asynchronous and active-low.
- digit_valid_i, input, 1: a digit is offered.
- digit_i, input, 4: digit value; valid range 0–9.
- digit_last_i, input, 1: the offered digit is the final digit of the number.
- digit_ready_o, output, 1: collector can accept a digit.
- clear_i, input, 1: synchronous abort/clear.
- bcd_o, output, 4*DIGITS: packed BCD operand, digit 0 in bits [3:0].
- count_o, output, CW: number of digits currently held.
- start_o, output, 1: launch request to the converter.
- conv_ready_i, input, 1: converter idle; start is accepted when start_o && conv_ready_i.
- conv_done_i, input, 1: converter result complete (one-cycle pulse).
- busy_o, output, 1: high in LAUNCH or WAIT.
- error_o, output, 1: sticky error flag.

## Operation
- States: IDLE (count_o=0), COLLECT, LAUNCH, WAIT.
- Digit handshake: a digit is accepted on the rising edge where digit_valid_i && digit_ready_o.
  - digit_ready_o = 1 in IDLE and COLLECT; 0 in LAUNCH and WAIT.
  - digit_ready_o does not depend on digit_valid_i.
- Accepted valid digit (0–9) with count_o < DIGITS:
  - bcd_o <= {bcd_o[4*DIGITS-5:0], digit_i}.
  - count_o increments.
  - IDLE goes to COLLECT.
- Accepted digit > 9:
  - Discarded entirely, including its last flag.
  - error_o <= 1; state and bcd_o unchanged.
- Accepted digit with count_o == DIGITS: overflow; see Configuration.
- Accepted valid digit with digit_last_i=1 moves to LAUNCH after the shift.
- LAUNCH:
  - start_o = 1.
  - When conv_ready_i=1, the handshake completes and the state moves to WAIT.
  - start_o is therefore high for at least 1 cycle.
- WAIT:
  - bcd_o is held constant.
  - On conv_done_i=1: go to IDLE, with bcd_o <= 0 and count_o <= 0.
- conv_done_i outside WAIT is ignored.
- clear_i:
  - In IDLE, COLLECT or LAUNCH: go to IDLE with bcd_o, count_o and error_o all cleared, and start_o low the next cycle.
  - In WAIT: ignored, because the converter is running.
- clear_i together with a digit handshake: the digit is consumed and discarded; clear wins.
- error_o is cleared only by clear_i or reset. It does not block collection or launch.

## Timing
- Reset values (asynchronous, while reset_ni=0): state IDLE, bcd_o=0, count_o=0, start_o=0, busy_o=0, error_o=0. digit_ready_o=1 once reset is released.
- Digit accepted at edge k: bcd_o and count_o update at edge k and are visible in cycle k+1.
- Last digit accepted at edge k: start_o=1 and busy_o=1 from cycle k+1.
- Start handshake at edge m: start_o=0 from cycle m+1.
- conv_done_i sampled at edge d: digit_ready_o=1 and busy_o=0 from cycle d+1.
- Minimum gap from the last digit to the next accepted digit: 3 cycles (launch, wait, done).
- All outputs are registered, except digit_ready_o, which is decoded from state only.

## Configuration
- Macro: BCD_COLLECTOR_ROLLING_EN.
- Defined (rolling window): an overflow digit still shifts in, the most-significant digit drops out, count_o stays at DIGITS, and error_o is not set. A last flag on that digit launches normally.
- Undefined (default): an overflow digit is discarded and error_o <= 1. If it carried digit_last_i, the state still moves to LAUNCH with the existing DIGITS digits, so no number is lost.

## Test plan
All scenarios use DIGITS=4.
- Digits 0,0,4,2 (last on the 2), conv_ready_i=1 -> bcd_o=16'h0042 and count_o=4. start_o is high for exactly 1 cycle, starting 1 cycle after the last digit. The bench then pulses conv_done_i -> bcd_o=0 and digit_ready_o=1 the next cycle.
- Digits 4,2 (last), conv_ready_i held 0 for 5 cycles -> start_o held high for 5 cycles, bcd_o=16'h0042 stable, digit_ready_o=0. Then conv_ready_i=1 -> start_o drops the next cycle.
- Digits 1,0xB,7 (last) -> bcd_o=16'h0017, error_o=1 persisting through launch. A later clear_i -> error_o=0.
- Digits 1,2,3,4,5 (last on the 5):
  - Without the macro: bcd_o=16'h1234, error_o=1, launch occurs.
  - With BCD_COLLECTOR_ROLLING_EN: bcd_o=16'h2345, error_o=0.
- Mid-operation events:
  - Digits 9,8 then clear_i -> bcd_o=0 and count_o=0.
  - clear_i in WAIT -> ignored, bcd_o held.
  - reset_ni low in LAUNCH -> start_o=0 immediately, without waiting for a clock edge.
